// File: rtl/amiga_bus_target_if.sv
// Bus-side and Pi-side signal bundle for amiga_bus_target.
// slave = the target block itself; master = whatever models the 68000 bus and the Pi side.
interface amiga_bus_target_if;
  // 68000 bus, target side
  logic [22:0] A_IN;
  logic [2:0]  FC_IN;
  logic        nAS_IN;
  logic        nUDS_IN;
  logic        nLDS_IN;
  logic        RnW_IN;
  logic [15:0] D_IN;
  logic [15:0] D_OUT;
  logic        D_OE;
  logic        nDTACK_OUT;
  logic        nDTACK_OE;
  logic        nBERR_OE;

  // Pi handshake: REQ_VALID rises with REQ_* stable and stays high until the
  // cycle where RSP_VALID pulses (or the bus cycle aborts / times out); the
  // RSP_VALID pulse is the acceptance, there is no separate ready.
  logic        REQ_VALID;
  logic [22:0] REQ_ADDR;
  logic        REQ_READ;
  logic [1:0]  REQ_BE;
  logic [15:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [15:0] RSP_RDATA;
  logic        RSP_ERR;

  // Status
  logic        BUSY;
  logic        ABORT;

  modport slave (
    input  A_IN, FC_IN, nAS_IN, nUDS_IN, nLDS_IN, RnW_IN, D_IN,
    input  RSP_VALID, RSP_RDATA, RSP_ERR,
    output D_OUT, D_OE, nDTACK_OUT, nDTACK_OE, nBERR_OE,
    output REQ_VALID, REQ_ADDR, REQ_READ, REQ_BE, REQ_WDATA,
    output BUSY, ABORT
  );

  modport master (
    output A_IN, FC_IN, nAS_IN, nUDS_IN, nLDS_IN, RnW_IN, D_IN,
    output RSP_VALID, RSP_RDATA, RSP_ERR,
    input  D_OUT, D_OE, nDTACK_OUT, nDTACK_OE, nBERR_OE,
    input  REQ_VALID, REQ_ADDR, REQ_READ, REQ_BE, REQ_WDATA,
    input  BUSY, ABORT
  );
endinterface

// File: rtl/amiga_bus_target.sv
// Amiga 68000 bus target: decodes an address window, forwards hits to the Pi as one request
// and ends the cycle with DTACK or BERR. Macro AMIGA_BUS_TARGET_TIMEOUT_EN adds a REQUEST timeout.
module amiga_bus_target #(
  parameter logic [23:0] BASE_ADDR      = 24'hE90000,
  parameter int          WINDOW_BITS    = 16,
  parameter logic [9:0]  TIMEOUT_CYCLES = 10'd1023
) (
  input  logic                  SYS_CLK,
  input  logic                  nRST,
  amiga_bus_target_if.slave     bus,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_REQUEST = 3'd2,
    S_ACK     = 3'd3,
    S_ERR     = 3'd4,
    S_RELEASE = 3'd5
  } state_e;

  state_e state_q, state_d;

  // Strobe synchronizers; bit 1 is the version the FSM looks at.
  logic [1:0] as_sync_q;
  logic [1:0] uds_sync_q;
  logic [1:0] lds_sync_q;
  logic [1:0] rnw_sync_q;

  always_ff @(posedge SYS_CLK or negedge nRST) begin
    if (!nRST) begin
      as_sync_q  <= 2'b11;
      uds_sync_q <= 2'b11;
      lds_sync_q <= 2'b11;
      rnw_sync_q <= 2'b11;
    end else begin
      as_sync_q  <= {as_sync_q[0],  bus.nAS_IN};
      uds_sync_q <= {uds_sync_q[0], bus.nUDS_IN};
      lds_sync_q <= {lds_sync_q[0], bus.nLDS_IN};
      rnw_sync_q <= {rnw_sync_q[0], bus.RnW_IN};
    end
  end

  logic nas_s;
  logic nuds_s;
  logic nlds_s;
  logic rnw_s;

  assign nas_s  = as_sync_q[1];
  assign nuds_s = uds_sync_q[1];
  assign nlds_s = lds_sync_q[1];
  assign rnw_s  = rnw_sync_q[1];

  // A_IN lacks A0; rebuild a byte address so the window compare is a plain shift.
  logic [23:0] addr_full;
  logic        in_window;
  logic        cpu_space;
  logic        hit;

  assign addr_full = {bus.A_IN, 1'b0};
  assign in_window = ((addr_full >> WINDOW_BITS) == (BASE_ADDR >> WINDOW_BITS));
  assign cpu_space = (bus.FC_IN == 3'b111);
  assign hit       = !nas_s && !cpu_space && in_window;

`ifdef AMIGA_BUS_TARGET_TIMEOUT_EN
  // Counter is held at zero outside REQUEST, so every entry starts fresh.
  logic [9:0] tmo_cnt_q;
  logic [9:0] tmo_cnt_d;
  logic       timeout;

  always_comb begin
    tmo_cnt_d = 10'd0;
    if (state_q == S_REQUEST) begin
      tmo_cnt_d = tmo_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge SYS_CLK or negedge nRST) begin
    if (!nRST) begin
      tmo_cnt_q <= 10'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign timeout = (state_q == S_REQUEST) && (tmo_cnt_q == (TIMEOUT_CYCLES - 10'd1));
`else
  logic       timeout;
  logic [9:0] unused_timeout_cycles;

  assign timeout               = 1'b0;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  logic data_strobe;
  logic rsp_take;
  logic abort_d;

  assign data_strobe = !nuds_s || !nlds_s;
  assign rsp_take    = (state_q == S_REQUEST) && !nas_s && bus.RSP_VALID;

  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!nas_s) begin
          state_d = hit ? S_DECODE : S_RELEASE;
        end
      end
      S_DECODE: begin
        if (nas_s) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (data_strobe) begin
          state_d = S_REQUEST;
        end
      end
      S_REQUEST: begin
        // A response in the same cycle as the timeout takes precedence.
        if (nas_s) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (bus.RSP_VALID) begin
          state_d = bus.RSP_ERR ? S_ERR : S_ACK;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_ACK, S_ERR: begin
        if (nas_s) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (nas_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output registers, all decoded from the next state so every bus/Pi output is a flop.
  logic [22:0] req_addr_q,  req_addr_d;
  logic        req_read_q,  req_read_d;
  logic [1:0]  req_be_q,    req_be_d;
  logic [15:0] req_wdata_q, req_wdata_d;
  logic        req_valid_q, req_valid_d;
  logic [15:0] d_out_q,     d_out_d;
  logic        d_oe_q,      d_oe_d;
  logic        dtack_out_q, dtack_out_d;
  logic        dtack_oe_q,  dtack_oe_d;
  logic        berr_oe_q,   berr_oe_d;
  logic        busy_q,      busy_d;
  logic        abort_q;
  logic        latch_req;
  logic        negate_dtack;

  assign latch_req    = (state_q == S_DECODE) && (state_d == S_REQUEST);
  assign negate_dtack = (state_q == S_ACK) && (state_d == S_RELEASE);

  always_comb begin
    req_addr_d  = req_addr_q;
    req_read_d  = req_read_q;
    req_be_d    = req_be_q;
    req_wdata_d = req_wdata_q;
    d_out_d     = d_out_q;
    if (latch_req) begin
      req_addr_d = bus.A_IN;
      req_read_d = rnw_s;
      req_be_d   = {!nuds_s, !nlds_s};
      if (!rnw_s) begin
        req_wdata_d = bus.D_IN;
      end
    end
    if (rsp_take) begin
      d_out_d = bus.RSP_RDATA;
    end
  end

  // DTACK is actively driven high for the single RELEASE cycle that follows ACK.
  always_comb begin
    req_valid_d = (state_d == S_REQUEST);
    d_oe_d      = (state_d == S_ACK) && req_read_q;
    dtack_out_d = (state_d != S_ACK);
    dtack_oe_d  = (state_d == S_ACK) || negate_dtack;
    berr_oe_d   = (state_d == S_ERR);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge SYS_CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      req_addr_q  <= 23'd0;
      req_read_q  <= 1'b0;
      req_be_q    <= 2'b00;
      req_wdata_q <= 16'd0;
      req_valid_q <= 1'b0;
      d_out_q     <= 16'd0;
      d_oe_q      <= 1'b0;
      dtack_out_q <= 1'b1;
      dtack_oe_q  <= 1'b0;
      berr_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_read_q  <= req_read_d;
      req_be_q    <= req_be_d;
      req_wdata_q <= req_wdata_d;
      req_valid_q <= req_valid_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      dtack_out_q <= dtack_out_d;
      dtack_oe_q  <= dtack_oe_d;
      berr_oe_q   <= berr_oe_d;
      busy_q      <= busy_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.REQ_ADDR   = req_addr_q;
  assign bus.REQ_READ   = req_read_q;
  assign bus.REQ_BE     = req_be_q;
  assign bus.REQ_WDATA  = req_wdata_q;
  assign bus.REQ_VALID  = req_valid_q;
  assign bus.D_OUT      = d_out_q;
  assign bus.D_OE       = d_oe_q;
  assign bus.nDTACK_OUT = dtack_out_q;
  assign bus.nDTACK_OE  = dtack_oe_q;
  assign bus.nBERR_OE   = berr_oe_q;
  assign bus.BUSY       = busy_q;
  assign bus.ABORT      = abort_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_amiga_bus_target.sv
// Directed bench for amiga_bus_target: drivers push expected events, a negedge monitor
// pops and compares them as the DUT produces requests, DTACK, BERR, aborts and releases.
module tb_amiga_bus_target;

  localparam int W = 48;
  localparam logic [3:0] K_REQ   = 4'd1;
  localparam logic [3:0] K_ACK   = 4'd2;
  localparam logic [3:0] K_BERR  = 4'd3;
  localparam logic [3:0] K_ABORT = 4'd4;
  localparam logic [3:0] K_REL   = 4'd5;

`ifdef AMIGA_BUS_TARGET_TIMEOUT_EN
  localparam logic [9:0] TMO = 10'd16;
`else
  localparam logic [9:0] TMO = 10'd1023;
`endif

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  amiga_bus_target_if bus();

  amiga_bus_target #(
    .BASE_ADDR      (24'hE90000),
    .WINDOW_BITS    (16),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .SYS_CLK     (clk),
    .nRST        (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int drive_cnt = 0;
  int doe_cnt   = 0;
  int ack_cnt   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] ev(input logic [3:0] k, input logic [41:0] p);
    return {k, 2'b00, p};
  endfunction

  function automatic logic [41:0] req_p(input logic [22:0] a, input logic rd,
                                        input logic [1:0] be, input logic [15:0] wd);
    return {a, rd, be, wd};
  endfunction

  function automatic logic [41:0] ack_p(input logic [15:0] dout, input logic doe);
    return {25'd0, dout, doe};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_cycle(input logic [23:0] addr, input logic [2:0] fc, input logic rnw,
                             input logic [1:0] be, input logic [15:0] wd);
    bus.A_IN   = addr[23:1];
    bus.FC_IN  = fc;
    bus.RnW_IN = rnw;
    bus.D_IN   = wd;
    tick(1);
    bus.nAS_IN = 1'b0;
    tick(1);
    bus.nUDS_IN = !be[1];
    bus.nLDS_IN = !be[0];
  endtask

  task automatic negate_strobes;
    bus.nAS_IN  = 1'b1;
    bus.nUDS_IN = 1'b1;
    bus.nLDS_IN = 1'b1;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!bus.REQ_VALID && n < 50) begin
      tick(1);
      n++;
    end
    check({name, "_req_seen"}, 32'(bus.REQ_VALID), 32'd1);
  endtask

  task automatic respond(input int dly, input logic [15:0] rd, input logic err);
    tick(dly);
    bus.RSP_RDATA = rd;
    bus.RSP_ERR   = err;
    bus.RSP_VALID = 1'b1;
    tick(1);
    bus.RSP_VALID = 1'b0;
    bus.RSP_ERR   = 1'b0;
  endtask

  task automatic finish_ack(input string name);
    int n;
    n = 0;
    negate_strobes();
    while (!bus.nDTACK_OUT && n < 20) begin
      tick(1);
      n++;
    end
    check({name, "_negation"}, 32'({bus.nDTACK_OE, bus.nDTACK_OUT, bus.D_OE}), 32'b110);
    tick(1);
    check({name, "_released"}, 32'({bus.nDTACK_OE, bus.BUSY}), 32'b00);
    tick(4);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic observe(input logic [W-1:0] got);
    logic [W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got %h expected none", got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL event_kind%0d: got %h expected %h", got[47:44], got, exp);
      end
    end
  endtask

  initial begin : monitor
    logic prev_req;
    logic prev_ack;
    logic prev_berr;
    logic prev_dtoe;
    logic ack_now;
    int   neg_cnt;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_berr = 1'b0;
    prev_dtoe = 1'b0;
    neg_cnt   = 0;
    forever begin
      @(negedge clk);
      ack_now = bus.nDTACK_OE && !bus.nDTACK_OUT;
      if (bus.REQ_VALID || bus.nDTACK_OE || bus.nBERR_OE || bus.D_OE) drive_cnt++;
      if (bus.D_OE) doe_cnt++;
      if (bus.REQ_VALID && !prev_req) begin
        observe(ev(K_REQ, req_p(bus.REQ_ADDR, bus.REQ_READ, bus.REQ_BE,
                                bus.REQ_READ ? 16'h0000 : bus.REQ_WDATA)));
      end
      if (ack_now && !prev_ack) begin
        ack_cnt++;
        observe(ev(K_ACK, ack_p(bus.D_OUT, bus.D_OE)));
        neg_cnt = 0;
      end
      if (bus.nBERR_OE && !prev_berr) observe(ev(K_BERR, 42'd0));
      if (bus.ABORT) observe(ev(K_ABORT, 42'd0));
      if (bus.nDTACK_OE && bus.nDTACK_OUT) neg_cnt++;
      if (prev_dtoe && !bus.nDTACK_OE) begin
        observe(ev(K_REL, 42'(neg_cnt)));
        neg_cnt = 0;
      end
      prev_req  = bus.REQ_VALID;
      prev_ack  = ack_now;
      prev_berr = bus.nBERR_OE;
      prev_dtoe = bus.nDTACK_OE;
    end
  end

  // ---------------- stimulus ----------------
  logic [23:0] miss_addr [2];
  logic [2:0]  miss_fc   [2];

  initial begin : stim
    int d0;
    int n;
    miss_addr[0] = 24'hE80000; miss_fc[0] = 3'd5;
    miss_addr[1] = 24'hE90000; miss_fc[1] = 3'd7;

    rst_n         = 1'b0;
    bus.A_IN      = 23'd0;
    bus.FC_IN     = 3'd0;
    bus.nAS_IN    = 1'b1;
    bus.nUDS_IN   = 1'b1;
    bus.nLDS_IN   = 1'b1;
    bus.RnW_IN    = 1'b1;
    bus.D_IN      = 16'd0;
    bus.RSP_VALID = 1'b0;
    bus.RSP_RDATA = 16'd0;
    bus.RSP_ERR   = 1'b0;
    tick(4);

    // Reset values
    check("rst_dout", 32'(bus.D_OUT), 32'd0);
    check("rst_ctrl", 32'({bus.D_OE, bus.nDTACK_OUT, bus.nDTACK_OE, bus.nBERR_OE,
                           bus.REQ_VALID, bus.REQ_READ, bus.BUSY, bus.ABORT}), 32'b0100_0000);
    check("rst_req_addr", 32'(bus.REQ_ADDR), 32'd0);
    check("rst_req_be_wdata", 32'({bus.REQ_BE, bus.REQ_WDATA}), 32'd0);
    rst_n = 1'b1;
    tick(3);
    check("post_rst_idle", 32'({dbg_state, bus.BUSY, bus.nDTACK_OUT}), 32'b000_0_1);

    // Word read at 0xE90010, Pi answers 0xBEEF 4 cycles after REQ_VALID
    exp_q.push_back(ev(K_REQ, req_p(23'h748008, 1'b1, 2'b11, 16'h0000)));
    exp_q.push_back(ev(K_ACK, ack_p(16'hBEEF, 1'b1)));
    exp_q.push_back(ev(K_REL, 42'd1));
    start_cycle(24'hE90010, 3'd5, 1'b1, 2'b11, 16'h0000);
    wait_req("read");
    check("read_busy", 32'(bus.BUSY), 32'd1);
    respond(3, 16'hBEEF, 1'b0);
    check("read_dtack_latency", 32'({bus.nDTACK_OE, bus.nDTACK_OUT}), 32'b10);
    check("read_dout", 32'(bus.D_OUT), 32'h0000BEEF);
    tick(3);
    check("read_dtack_hold", 32'({bus.nDTACK_OE, bus.nDTACK_OUT, bus.D_OE}), 32'b101);
    finish_ack("read");

    // Lower-byte write of 0x00A5 at 0xE90001
    exp_q.push_back(ev(K_REQ, req_p(23'h748000, 1'b0, 2'b01, 16'h00A5)));
    exp_q.push_back(ev(K_ACK, ack_p(16'h0000, 1'b0)));
    exp_q.push_back(ev(K_REL, 42'd1));
    d0 = doe_cnt;
    start_cycle(24'hE90001, 3'd5, 1'b0, 2'b01, 16'h00A5);
    wait_req("write");
    respond(2, 16'h0000, 1'b0);
    check("write_dtack_latency", 32'({bus.nDTACK_OE, bus.nDTACK_OUT}), 32'b10);
    finish_ack("write");
    check("write_doe_never", 32'(doe_cnt - d0), 32'd0);

    // Misses: outside the window, and CPU space inside the window
    for (int i = 0; i < 2; i++) begin
      d0 = drive_cnt;
      start_cycle(miss_addr[i], miss_fc[i], 1'b1, 2'b11, 16'h0000);
      tick(8);
      check("miss_busy", 32'(bus.BUSY), 32'd1);
      negate_strobes();
      tick(6);
      check("miss_no_drive", 32'(drive_cnt - d0), 32'd0);
      check("miss_idle", 32'(bus.BUSY), 32'd0);
    end

    // Abort 3 cycles into REQUEST, then a stray response that must be ignored
    exp_q.push_back(ev(K_REQ, req_p(23'h748010, 1'b1, 2'b11, 16'h0000)));
    exp_q.push_back(ev(K_ABORT, 42'd0));
    d0 = ack_cnt;
    start_cycle(24'hE90020, 3'd5, 1'b1, 2'b11, 16'h0000);
    wait_req("abort");
    tick(3);
    negate_strobes();
    n = 0;
    while (bus.REQ_VALID && n < 10) begin
      tick(1);
      n++;
    end
    check("abort_req_drop", 32'(bus.REQ_VALID), 32'd0);
    tick(2);
    respond(0, 16'h5555, 1'b0);
    tick(4);
    check("abort_no_dtack", 32'(ack_cnt - d0), 32'd0);
    check("abort_dout_kept", 32'(bus.D_OUT), 32'd0);
    check("abort_idle", 32'({bus.BUSY, bus.nDTACK_OE}), 32'b00);

    // Pi-signalled error: BERR held until nAS negates
    exp_q.push_back(ev(K_REQ, req_p(23'h748020, 1'b1, 2'b11, 16'h0000)));
    exp_q.push_back(ev(K_BERR, 42'd0));
    start_cycle(24'hE90040, 3'd5, 1'b1, 2'b11, 16'h0000);
    wait_req("err");
    respond(1, 16'hDEAD, 1'b1);
    check("err_berr", 32'({bus.nBERR_OE, bus.nDTACK_OE, bus.REQ_VALID}), 32'b100);
    tick(5);
    check("err_hold", 32'(bus.nBERR_OE), 32'd1);
    negate_strobes();
    n = 0;
    while (bus.nBERR_OE && n < 10) begin
      tick(1);
      n++;
    end
    check("err_release", 32'(bus.nBERR_OE), 32'd0);
    tick(4);
    check("err_idle", 32'(bus.BUSY), 32'd0);

`ifdef AMIGA_BUS_TARGET_TIMEOUT_EN
    // No response: BERR exactly 16 cycles after REQ_VALID rises
    exp_q.push_back(ev(K_REQ, req_p(23'h748030, 1'b1, 2'b11, 16'h0000)));
    exp_q.push_back(ev(K_BERR, 42'd0));
    start_cycle(24'hE90060, 3'd5, 1'b1, 2'b11, 16'h0000);
    wait_req("tmo");
    n = 0;
    while (!bus.nBERR_OE && n < 100) begin
      tick(1);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'd16);
    check("tmo_req_drop", 32'(bus.REQ_VALID), 32'd0);
    tick(5);
    check("tmo_hold", 32'(bus.nBERR_OE), 32'd1);
    negate_strobes();
    tick(5);
    check("tmo_release", 32'({bus.nBERR_OE, bus.BUSY}), 32'b00);
`else
    // No response for a long time: no BERR, request stays pending
    exp_q.push_back(ev(K_REQ, req_p(23'h748030, 1'b1, 2'b11, 16'h0000)));
    exp_q.push_back(ev(K_ACK, ack_p(16'h0F0F, 1'b1)));
    exp_q.push_back(ev(K_REL, 42'd1));
    start_cycle(24'hE90060, 3'd5, 1'b1, 2'b11, 16'h0000);
    wait_req("wait");
    tick(40);
    check("wait_no_berr", 32'({bus.nBERR_OE, bus.REQ_VALID}), 32'b01);
    respond(0, 16'h0F0F, 1'b0);
    check("wait_dtack_latency", 32'({bus.nDTACK_OE, bus.nDTACK_OUT}), 32'b10);
    finish_ack("wait");
`endif

    // Asynchronous reset while in ACK, then a normal cycle
    exp_q.push_back(ev(K_REQ, req_p(23'h748040, 1'b1, 2'b11, 16'h0000)));
    exp_q.push_back(ev(K_ACK, ack_p(16'h1234, 1'b1)));
    exp_q.push_back(ev(K_REL, 42'd0));
    start_cycle(24'hE90080, 3'd5, 1'b1, 2'b11, 16'h0000);
    wait_req("rst");
    respond(1, 16'h1234, 1'b0);
    tick(2);
    check("rst_in_ack", 32'({bus.nDTACK_OE, bus.nDTACK_OUT, bus.D_OE}), 32'b101);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_release", 32'({bus.nDTACK_OE, bus.D_OE, bus.REQ_VALID, bus.nBERR_OE}), 32'd0);
    check("rst_async_dout", 32'(bus.D_OUT), 32'd0);
    negate_strobes();
    tick(3);
    rst_n = 1'b1;
    tick(3);

    exp_q.push_back(ev(K_REQ, req_p(23'h748008, 1'b1, 2'b11, 16'h0000)));
    exp_q.push_back(ev(K_ACK, ack_p(16'hCAFE, 1'b1)));
    exp_q.push_back(ev(K_REL, 42'd1));
    start_cycle(24'hE90010, 3'd5, 1'b1, 2'b11, 16'h0000);
    wait_req("after_rst");
    respond(2, 16'hCAFE, 1'b0);
    check("after_rst_dtack", 32'({bus.nDTACK_OE, bus.nDTACK_OUT}), 32'b10);
    finish_ack("after_rst");

    tick(10);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/amiga_bus_target.md
# amiga_bus_target

- Responds to Amiga 68000 bus cycles whose address falls in a configured window; it is the target-side counterpart of the FPGA's bus-initiator path.
- Synchronizes the bus strobes into the system clock domain and decodes the access.
- Forwards each hit to the Pi side as a single-word request and holds the bus until the Pi answers.
- Terminates the cycle with nDTACK, or with nBERR on timeout.

## Interface
Parameters:
- BASE_ADDR, 24'hE90000, window base; must be aligned to 2^WINDOW_BITS
- WINDOW_BITS, 16, window size is 2^WINDOW_BITS bytes (1..23)
- TIMEOUT_CYCLES, 1023, SYS_CLK cycles from REQ_VALID rise to BERR (10-bit counter)

Ports (one clock; reset is asynchronous and active-low):
- SYS_CLK  in  1  system clock (PLL, 120-143 MHz)
- nRST  in  1  asynchronous active-low reset
- A_IN  in  23  address bus A[23:1]
- FC_IN  in  3  function code
- nAS_IN, nUDS_IN, nLDS_IN, RnW_IN  in  1 each  bus strobes and direction
- D_IN  in  16  data bus in
- D_OUT  out  16  read data to bus
- D_OE  out  1  data bus output enable
- nDTACK_OUT  out  1  DTACK level
- nDTACK_OE  out  1  DTACK enable
- nBERR_OE  out  1  drives nBERR low when 1
- REQ_VALID  out  1  request pending to Pi
- REQ_ADDR  out  23  latched A[23:1]
- REQ_READ  out  1  1 = read
- REQ_BE  out  2  {UDS, LDS} active-high byte enables
- REQ_WDATA  out  16  latched write data
- RSP_VALID  in  1  one-cycle completion pulse from Pi side
- RSP_RDATA  in  16  read data, valid with RSP_VALID
- RSP_ERR  in  1  terminate with BERR instead of DTACK
- BUSY  out  1  state != IDLE
- ABORT  out  1  one-cycle pulse when nAS negates before completion

## Operation
- nAS_IN, nUDS_IN, nLDS_IN and RnW_IN pass through 2-flop synchronizers. A_IN, FC_IN and D_IN are sampled directly, because they are stable while the synced strobes are low.
- Hit: synced nAS low, FC_IN != 3'b111 (CPU space is ignored), and A_IN[23:WINDOW_BITS] == BASE_ADDR[23:WINDOW_BITS].
- State machine:
  - IDLE: on hit, go to DECODE. On a miss, go to RELEASE and wait out the cycle.
  - DECODE: wait for synced UDS or LDS low. Then latch REQ_ADDR, REQ_READ = synced RnW, REQ_BE, and REQ_WDATA = D_IN (writes only). Go to REQUEST.
  - REQUEST: REQ_VALID = 1. On RSP_VALID, latch RSP_RDATA into D_OUT.
    - RSP_ERR = 0 → ACK.
    - RSP_ERR = 1 → ERR.
  - ACK: nDTACK_OE = 1, nDTACK_OUT = 0. D_OE = REQ_READ. Go to RELEASE when synced nAS is high.
  - ERR: nBERR_OE = 1. Go to RELEASE when synced nAS is high.
  - RELEASE: D_OE = 0 and nBERR_OE = 0. nDTACK_OUT = 1 with nDTACK_OE still 1 for exactly one cycle (active negation). Then nDTACK_OE = 0 and go to IDLE, but only when synced nAS is high.
- Abort: synced nAS goes high in DECODE or REQUEST → REQ_VALID drops, ABORT pulses, go to IDLE. No DTACK is driven.
- RSP_VALID outside REQUEST is ignored.
- RSP_VALID and timeout in the same cycle: the response wins.
- A back-to-back cycle is accepted only after IDLE is re-entered.

## Timing
- Reset values: D_OUT = 0, D_OE = 0, nDTACK_OUT = 1, nDTACK_OE = 0, nBERR_OE = 0, REQ_VALID = 0, REQ_ADDR/REQ_BE/REQ_WDATA = 0, REQ_READ = 0, BUSY = 0, ABORT = 0.
- Reset mid-cycle releases all bus drivers immediately (asynchronous).
- Strobe to internal view: 2 cycles.
- REQ_VALID rises 1 cycle after DECODE sees a data strobe.
- RSP_VALID to nDTACK low: 1 cycle, registered. D_OUT is valid on the same edge as nDTACK low.
- Synced nAS high to D_OE low: 1 cycle. nDTACK_OE low follows 1 cycle later.
- All outputs are registered.

## Configuration
- Macro: AMIGA_BUS_TARGET_TIMEOUT_EN.
- Defined:
  - A counter runs in REQUEST, reset on entry.
  - Reaching TIMEOUT_CYCLES → ERR: REQ_VALID drops, and nBERR is driven until nAS negates.
- Undefined:
  - No counter; REQUEST waits indefinitely.
  - nBERR_OE is driven only via RSP_ERR.

## Test plan
- Word read at 0xE90010, FC = 5. Pi returns 0xBEEF, RSP_ERR = 0, 4 cycles after REQ_VALID → REQ_ADDR = 0x748008, REQ_BE = 2'b11, D_OUT = 0xBEEF, nDTACK low; after nAS high, one cycle nDTACK high, then released.
- Lower-byte write 0x00A5 at 0xE90001 → REQ_READ = 0, REQ_BE = 2'b01, REQ_WDATA = 0x00A5, D_OE stays 0 throughout.
- Access at 0xE80000, or at 0xE90000 with FC = 7 → REQ_VALID never asserts; nDTACK_OE, nBERR_OE and D_OE stay 0.
- nAS negated 3 cycles into REQUEST → ABORT pulses once; REQ_VALID drops; a later RSP_VALID is ignored; no DTACK.
- With AMIGA_BUS_TARGET_TIMEOUT_EN and TIMEOUT_CYCLES = 16, no response → nBERR_OE = 1 after 16 cycles and held until nAS high.
- nRST asserted while in ACK → nDTACK_OE, D_OE and REQ_VALID go to 0 asynchronously; the next cycle completes normally after reset release.
